event_time_packer: RTL and testbench

- Consumer end of the timestamp path: accepts timestamped pixel events (absolute wall-clock timestamp plus pixel address) and packs them into a compact output word stream.
- Each event becomes a short delta-time EVENT word. A full TIME word is inserted only when the delta overflows or no time base exists yet.
- Sits between the arbiter/wall-clock output and the readout interface. Buffers bursts in a small FIFO and exposes a valid/ready output.

---
 rtl/ebc_pkg.sv | 25 ++
 rtl/event_time_packer_if.sv | 31 +++
 rtl/ebc_sync_fifo.sv | 57 +++++
 rtl/event_time_packer.sv | 133 +++++++++++++
 tb/tb_event_time_packer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ebc_pkg.sv
// Purpose: shared types for the event time packer (FSM states, word-type tags, FIFO entry layout).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ebc_pkg;

   // Default widths; the FIFO entry layout below is built from these.
   localparam int EBC_SIZE   = 32;
   localparam int EBC_ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      S_TIME = 2'd1,
      S_EVT  = 2'd2
   } state_t;

   // MSB of every output word tells the reader how to parse the rest.
   localparam logic WT_EVENT = 1'b0;
   localparam logic WT_TIME  = 1'b1;

   typedef struct packed {
      logic [EBC_SIZE-1:0]   ts;
      logic [EBC_ADDR_W-1:0] addr;
   } fifo_entry_t;

endpackage

// File: rtl/event_time_packer_if.sv
// Purpose: event input stream and packed-word output stream of the event time packer.
// Latency: n/a (wires only).
// Backpressure: event side stalls on event_ready_o, word side on pkt_ready_i.
// Ports: master = upstream/downstream side, slave = packer side.
interface event_time_packer_if #(
   parameter int SIZE    = 32,
   parameter int ADDR_W  = 16,
   parameter int DELTA_W = 16,
   parameter int DROP_W  = 16
) ();
   localparam int PKT_W = 1 + DELTA_W + ADDR_W;

   logic              event_valid_i;
   logic [SIZE-1:0]   timestamp_i;
   logic [ADDR_W-1:0] event_addr_i;
   logic              event_ready_o;
   logic              pkt_valid_o;
   logic              pkt_ready_i;
   logic [PKT_W-1:0]  pkt_data_o;
   logic [DROP_W-1:0] drop_count_o;

   modport master (
      output event_valid_i, timestamp_i, event_addr_i, pkt_ready_i,
      input  event_ready_o, pkt_valid_o, pkt_data_o, drop_count_o
   );

   modport slave (
      input  event_valid_i, timestamp_i, event_addr_i, pkt_ready_i,
      output event_ready_o, pkt_valid_o, pkt_data_o, drop_count_o
   );
endinterface

// File: rtl/ebc_sync_fifo.sv
// Purpose: generic single-clock FIFO with registered occupancy, full/empty flags.
// Latency: written entry is visible on rd_data_o the cycle after the write.
// Backpressure: writes while full and pops while empty are ignored.
// Ports: clk_i/reset_i (sync, active high), wr_en_i/wr_data_i, rd_en_i/rd_data_o, full_o, empty_o.
module ebc_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr, rd;

   // Flags come straight from the registered count, so a pop never frees a slot in the same cycle.
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign wr        = wr_en_i && !full_o;
   assign rd        = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (wr) mem_q[wr_ptr_q] <= wr_data_i;
   end
endmodule

// File: rtl/event_time_packer.sv
// Purpose: packs timestamped pixel events into delta-time EVENT words, inserting TIME words when needed.
// Latency: event accepted in cycle 0 appears as a word in cycle 2 (empty FIFO, no TIME word).
// Backpressure: pkt_ready_i low holds the word; a full FIFO drops events and counts them.
// Ports: clk_i, reset_i (sync, active high), bus (slave view of event_time_packer_if).
module event_time_packer
   import ebc_pkg::*;
#(
   parameter int SIZE    = EBC_SIZE,
   parameter int ADDR_W  = EBC_ADDR_W,
   parameter int DELTA_W = 16,
   parameter int DEPTH   = 8,
   parameter int DROP_W  = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   event_time_packer_if.slave bus
);
   localparam int PKT_W = 1 + DELTA_W + ADDR_W;
   localparam logic [SIZE-1:0] MAX_DELTA = SIZE'((64'd1 << DELTA_W) - 64'd1);

   fifo_entry_t       wr_entry, rd_entry;
   logic              full, empty, pop;
   logic [SIZE-1:0]   delta;
   logic              need_time;

   state_t            state_q, state_d;
   logic [SIZE-1:0]   base_ts_q, base_ts_d;
   logic              base_valid_q, base_valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PKT_W-1:0]  pkt_data_q, pkt_data_d;
   logic              pkt_valid_q, pkt_valid_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   function automatic logic [PKT_W-1:0] time_word(input logic [SIZE-1:0] ts);
      logic [PKT_W-1:0] w;
      w            = '0;
      w[PKT_W-1]   = WT_TIME;
      w[SIZE-1:0]  = ts;
      return w;
   endfunction

   function automatic logic [PKT_W-1:0] evt_word(input logic [DELTA_W-1:0] d,
                                                 input logic [ADDR_W-1:0] a);
      return {WT_EVENT, d, a};
   endfunction

   assign wr_entry = '{ts: bus.timestamp_i, addr: bus.event_addr_i};

   ebc_sync_fifo #(.W($bits(fifo_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (bus.event_valid_i),
      .wr_data_i (wr_entry),
      .rd_en_i   (pop),
      .rd_data_o (rd_entry),
      .full_o    (full),
      .empty_o   (empty)
   );

   // Modular difference: wrap and backwards time both show up as a huge delta.
   assign delta     = rd_entry.ts - base_ts_q;
   assign need_time = !base_valid_q || (delta > MAX_DELTA);

   always_comb begin
      state_d      = state_q;
      base_ts_d    = base_ts_q;
      base_valid_d = base_valid_q;
      addr_d       = addr_q;
      pkt_data_d   = pkt_data_q;
      pkt_valid_d  = pkt_valid_q;
      drop_d       = drop_q;
      pop          = 1'b0;

      if (bus.event_valid_i && full && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

      case (state_q)
         IDLE:   pop = !empty;
         S_TIME: if (bus.pkt_ready_i) begin
                    state_d    = S_EVT;
                    pkt_data_d = evt_word('0, addr_q);
                 end
         S_EVT:  if (bus.pkt_ready_i) begin
                    if (!empty) begin
                       pop = 1'b1;
                    end else begin
                       state_d     = IDLE;
                       pkt_valid_d = 1'b0;
                    end
                 end
         default: state_d = IDLE;
      endcase

      // The base always advances to the popped timestamp, so deltas chain event to event.
      if (pop) begin
         addr_d      = rd_entry.addr;
         base_ts_d   = rd_entry.ts;
         pkt_valid_d = 1'b1;
         if (need_time) begin
            base_valid_d = 1'b1;
            state_d      = S_TIME;
            pkt_data_d   = time_word(rd_entry.ts);
         end else begin
            state_d    = S_EVT;
            pkt_data_d = evt_word(delta[DELTA_W-1:0], rd_entry.addr);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         base_ts_q    <= '0;
         base_valid_q <= 1'b0;
         addr_q       <= '0;
         pkt_data_q   <= '0;
         pkt_valid_q  <= 1'b0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         base_ts_q    <= base_ts_d;
         base_valid_q <= base_valid_d;
         addr_q       <= addr_d;
         pkt_data_q   <= pkt_data_d;
         pkt_valid_q  <= pkt_valid_d;
         drop_q       <= drop_d;
      end
   end

   assign bus.event_ready_o = !full;
   assign bus.pkt_valid_o   = pkt_valid_q;
   assign bus.pkt_data_o    = pkt_data_q;
   assign bus.drop_count_o  = drop_q;
endmodule

// File: tb/tb_event_time_packer.sv
// Purpose: directed self-checking bench for event_time_packer with hand-computed words.
// Latency: checks exact first-word timing plus drained word streams.
// Backpressure: exercises pkt_ready_i stalls, FIFO overflow drops and mid-packet reset.
module tb_event_time_packer;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   event_time_packer_if bus ();

   event_time_packer dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [32:0] cap_q [$];
   logic [32:0] exp_w [16];

   // Record every word that completes a handshake at a clock edge.
   always @(posedge clk) begin
      if (!reset && bus.pkt_valid_o && bus.pkt_ready_i) cap_q.push_back(bus.pkt_data_o);
   end

   function automatic logic [32:0] tw(input logic [31:0] ts);
      return {1'b1, ts};
   endfunction

   function automatic logic [32:0] ew(input logic [15:0] d, input logic [15:0] a);
      return {1'b0, d, a};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] ts, input logic [15:0] a);
      bus.event_valid_i = 1'b1;
      bus.timestamp_i   = ts;
      bus.event_addr_i  = a;
      tick();
      bus.event_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      bus.event_valid_i = 1'b0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic check_stream(input string tag, input int n);
      logic [32:0] obs;
      chk({tag, ".count"}, 33'(cap_q.size()), 33'(n));
      for (int i = 0; i < n; i++) begin
         obs = (i < cap_q.size()) ? cap_q[i] : 'x;
         chk($sformatf("%s[%0d]", tag, i), obs, exp_w[i]);
      end
   endtask

   initial begin
      bus.event_valid_i = 1'b0;
      bus.timestamp_i   = '0;
      bus.event_addr_i  = '0;
      bus.pkt_ready_i   = 1'b1;
      reset = 1'b1;
      tick(2);

      // Reset state
      chk("rst.valid", 33'(bus.pkt_valid_o), 33'd0);
      chk("rst.data",  bus.pkt_data_o, 33'd0);
      chk("rst.drop",  33'(bus.drop_count_o), 33'd0);
      chk("rst.ready", 33'(bus.event_ready_o), 33'd1);
      reset = 1'b0;

      // Single event: exact latency, TIME then EVENT
      cap_q.delete();
      send(32'd100, 16'h0012);
      chk("t1.cyc1.valid", 33'(bus.pkt_valid_o), 33'd0);
      tick();
      chk("t1.cyc2.valid", 33'(bus.pkt_valid_o), 33'd1);
      chk("t1.cyc2.data",  bus.pkt_data_o, tw(32'd100));
      tick();
      chk("t1.cyc3.valid", 33'(bus.pkt_valid_o), 33'd1);
      chk("t1.cyc3.data",  bus.pkt_data_o, ew(16'd0, 16'h0012));
      tick();
      chk("t1.cyc4.valid", 33'(bus.pkt_valid_o), 33'd0);

      // Back-to-back events within delta range
      do_reset();
      cap_q.delete();
      send(32'd100,   16'h0001);
      send(32'd150,   16'h0002);
      send(32'd65635, 16'h0003);
      tick(10);
      exp_w[0] = tw(32'd100);
      exp_w[1] = ew(16'd0,     16'h0001);
      exp_w[2] = ew(16'd50,    16'h0002);
      exp_w[3] = ew(16'd65485, 16'h0003);
      check_stream("t2", 4);

      // Delta overflow by one
      do_reset();
      cap_q.delete();
      send(32'd100,   16'h0005);
      send(32'd65636, 16'h0006);
      tick(10);
      exp_w[0] = tw(32'd100);
      exp_w[1] = ew(16'd0, 16'h0005);
      exp_w[2] = tw(32'd65636);
      exp_w[3] = ew(16'd0, 16'h0006);
      check_stream("t3", 4);

      // Timestamp wrap (small delta) then backwards time (large delta)
      do_reset();
      cap_q.delete();
      send(32'hFFFF_FFF0, 16'h0007);
      send(32'h0000_0005, 16'h0008);
      send(32'h0000_0004, 16'h0009);
      tick(12);
      exp_w[0] = tw(32'hFFFF_FFF0);
      exp_w[1] = ew(16'd0,  16'h0007);
      exp_w[2] = ew(16'd21, 16'h0008);
      exp_w[3] = tw(32'h0000_0004);
      exp_w[4] = ew(16'd0,  16'h0009);
      check_stream("t4", 5);

      // Stalled output, FIFO overflow, then drain in order
      do_reset();
      cap_q.delete();
      bus.pkt_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send(32'(200 + i), 16'(16'h0100 + i));
         if (i == 3) chk("t5.hold.early", bus.pkt_data_o, tw(32'd200));
      end
      chk("t5.ready_low", 33'(bus.event_ready_o), 33'd0);
      chk("t5.drop",      33'(bus.drop_count_o), 33'd1);
      chk("t5.hold.valid", 33'(bus.pkt_valid_o), 33'd1);
      chk("t5.hold.late", bus.pkt_data_o, tw(32'd200));
      bus.pkt_ready_i = 1'b1;
      tick(15);
      exp_w[0] = tw(32'd200);
      exp_w[1] = ew(16'd0, 16'h0100);
      for (int k = 1; k <= 8; k++) exp_w[k+1] = ew(16'd1, 16'(16'h0100 + k));
      check_stream("t5", 10);
      chk("t5.ready_back", 33'(bus.event_ready_o), 33'd1);

      // Reset while presenting a TIME word with events still buffered
      cap_q.delete();
      bus.pkt_ready_i = 1'b0;
      send(32'h0010_0000, 16'h0030);
      send(32'h0010_0001, 16'h0031);
      chk("t6.pre.valid", 33'(bus.pkt_valid_o), 33'd1);
      chk("t6.pre.data",  bus.pkt_data_o, tw(32'h0010_0000));
      reset = 1'b1;
      tick();
      chk("t6.rst.valid", 33'(bus.pkt_valid_o), 33'd0);
      chk("t6.rst.drop",  33'(bus.drop_count_o), 33'd0);
      chk("t6.rst.data",  bus.pkt_data_o, 33'd0);
      chk("t6.rst.ready", 33'(bus.event_ready_o), 33'd1);
      reset = 1'b0;
      bus.pkt_ready_i = 1'b1;
      cap_q.delete();
      send(32'h0010_0002, 16'h0032);
      tick(8);
      exp_w[0] = tw(32'h0010_0002);
      exp_w[1] = ew(16'd0, 16'h0032);
      check_stream("t6", 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
